ws2812b_frame_sequencer: RTL
============================

// Module: ws2812b_frame_sequencer
// PURPOSE
//  Frame-level controller for the ws2812b serializer core. Holds a palette-indexed frame
//  buffer (2-bit index per LED, 4-entry 24-bit GRB palette) written over the TinyQV byte bus.
//  On START it streams LEN+1 pixels to the core over valid/ready and asserts latch on the last
//  pixel. Optional AUTO mode re-sends the frame after a fixed gap. Sits between bus and ws2812b.
// PARAMETERS
//  NUM_LEDS    16    frame buffer depth (LEDs); 2..64
//  GAP_CYCLES  1024  idle clk cycles between frames in AUTO mode; >=1
// PORTS
//  clk         in   1   clock (64 MHz nominal)
//  rst_n       in   1   reset, asynchronous, active-low
//  address     in   4   register address
//  data_write  in   1   write strobe, 1 cycle
//  data_in     in   8   write data
//  data_out    out  8   read data, combinational from address
//  px_data     out  24  GRB pixel to core, registered
//  px_valid    out  1   pixel offer to core
//  px_latch    out  1   last pixel of frame; valid only with px_valid
//  px_ready    in   1   core ready; drops on cycle after acceptance, rises when idle again
// BEHAVIOUR
//  Register map: 0x0 CTRL  W: b0 START, b1 AUTO (stored), b2 ABORT; R: {5'b0,auto,done,busy}
//   0x1 LEN (LEDs-1, write clipped to NUM_LEDS-1); 0x2 IDX (fb pointer, 6b)
//   0x3 PIX W: fb[IDX]<=data_in[1:0], IDX<=IDX+1 wrapping NUM_LEDS-1->0; R: {6'b0,fb[IDX]}, no incr
//   0x4+3p+{0,1,2}: palette p (0..3) G,R,B bytes, R/W
//  Reset: px_valid=0 px_latch=0 px_data=0 busy=0 done=0 auto=0 LEN=NUM_LEDS-1 IDX=0,
//   palette=0, fb=0, state=IDLE. Async assert, sync-deassert assumed upstream.
//  FSM: IDLE -> LOAD on CTRL write with START=1 (clears done, ptr<=0, busy<=1)
//   LOAD: px_data<=palette[fb[ptr]], px_latch<=(ptr==LEN); -> SEND (1 cycle)
//   SEND: px_valid=1 held until px_ready==0 (core accepted), then px_valid<=0 -> WAITRDY
//   WAITRDY: wait px_ready==1; then if abort_pend -> IDLE (busy=0, done unchanged)
//            else if ptr==LEN: done<=1; AUTO ? -> GAP : -> IDLE (busy=0)
//            else ptr<=ptr+1 -> LOAD
//   GAP: count GAP_CYCLES down; abort or AUTO cleared -> IDLE; at 0: ptr<=0 -> LOAD
//  Latency: START write in cycle N -> LOAD N+1 -> px_valid=1 from N+2.
//  px_data/px_latch stable for the whole SEND; palette/fb/LEN writes during busy are legal
//   and affect only pixels loaded afterwards (LEN lowered below ptr: frame ends at next pixel).
//  START while busy: ignored (AUTO bit still updated). ABORT: sets abort_pend; in-flight pixel
//   completes (no truncated serial word); frame left unlatched; abort_pend cleared on IDLE.
//  START+ABORT same write: ABORT wins when busy; START wins when idle.
//  AUTO=0 written during frame: current frame completes, no further frames.
//  Simultaneous bus write and FSM fb read: no conflict (separate read port, write-through not
//   required). Reset mid-frame: all outputs return to reset values immediately.
// STRUCTURE
//  Package ws2812b_pkg: register address localparams (REG_CTRL..REG_PAL0), CTRL bit indices,
//   FSM state encoding {IDLE,LOAD,SEND,WAITRDY,GAP}, palette/index widths.
//  Sub-module ws2812b_frame_store: fb array + palette; bus write/read port and one
//   combinational pixel read port (ptr -> 24b colour). FSM, counters and bus decode stay top.
// TESTING (bench with behavioural ws2812b model: ready low 30 cycles after accept)
//  1 Reset: rst_n low mid-SEND -> px_valid=0, px_data=0, CTRL reads 0x00, LEN reads 0x0F.
//  2 Pal0=00/00/00, pal1=G10 R20 B30; LEN=2; IDX=0; PIX 1,0,1; START -> core sees
//    0x102030,0x000000,0x102030; px_latch only on 3rd; CTRL reads 0x02 after.
//  3 START cycle N -> px_valid first high N+2; second START while busy -> no extra pixels.
//  4 IDX=15, PIX x2 -> writes fb[15], fb[0]; IDX reads 1; LEN write 0xFF reads 0x0F.
//  5 AUTO=1,LEN=0 -> frames repeat, gap >= GAP_CYCLES between px_ready rise and next valid;
//    write AUTO=0 -> exactly one more frame max, then busy=0.
//  6 ABORT during pixel 1 of LEN=5 -> pixel 1 completes, no further valid, no latch, done=0.

Source files
------------

// File: rtl/ws2812b_frame_sequencer_pkg.sv
// Shared definitions for the ws2812b frame sequencer slice.
// Contents: register map addresses, CTRL bit positions, FSM state type,
// field widths and a palette address helper.
package ws2812b_pkg;

    localparam logic [3:0] REG_CTRL = 4'h0;
    localparam logic [3:0] REG_LEN  = 4'h1;
    localparam logic [3:0] REG_IDX  = 4'h2;
    localparam logic [3:0] REG_PIX  = 4'h3;
    localparam logic [3:0] REG_PAL0 = 4'h4;

    localparam int CTRL_START = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_ABORT = 2;

    localparam int IDX_W     = 6;   // frame buffer pointer / LEN width
    localparam int PIX_W     = 2;   // palette index per LED
    localparam int COLOR_W   = 24;  // GRB colour
    localparam int PAL_BYTES = 12;  // 4 entries x {G,R,B}

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAITRDY,
        ST_GAP
    } state_t;

    // Byte offset of the G byte of palette entry p (3*p).
    function automatic logic [3:0] pal_base(input logic [PIX_W-1:0] p);
        return {1'b0, p, 1'b0} + {2'b00, p};
    endfunction

endpackage

// File: rtl/ws2812b_frame_sequencer_if.sv
// Bus and pixel-stream interfaces of the ws2812b frame sequencer.
//  ws2812b_bus_if : TinyQV byte bus (address, data_write, data_in, data_out);
//                   master = CPU side, slave = sequencer.
//  ws2812b_px_if  : pixel stream (px_data, px_valid, px_latch, px_ready);
//                   master = sequencer, slave = serializer core.
interface ws2812b_bus_if;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (output address, data_write, data_in, input data_out);
    modport slave  (input address, data_write, data_in, output data_out);
endinterface

interface ws2812b_px_if;
    logic [ws2812b_pkg::COLOR_W-1:0] px_data;
    logic                            px_valid;
    logic                            px_latch;
    logic                            px_ready;

    modport master (output px_data, px_valid, px_latch, input px_ready);
    modport slave  (input px_data, px_valid, px_latch, output px_ready);
endinterface

// File: rtl/ws2812b_frame_sequencer_frame_store.sv
// Frame buffer (2-bit palette index per LED) plus 4-entry GRB palette.
// Ports:
//  clk, rst_n            clock, async active-low reset (clears all storage)
//  fb_we/fb_waddr/fb_wdata   bus write into frame buffer
//  fb_raddr -> fb_rdata      bus read of frame buffer
//  pal_we/pal_addr/pal_wdata bus write of palette byte (0..11)
//  pal_addr -> pal_rdata     bus read of palette byte
//  pix_ptr -> pix_color      combinational pixel lookup for the sequencer
module ws2812b_frame_store
    import ws2812b_pkg::*;
#(
    parameter int NUM_LEDS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fb_we,
    input  logic [IDX_W-1:0]   fb_waddr,
    input  logic [PIX_W-1:0]   fb_wdata,
    input  logic [IDX_W-1:0]   fb_raddr,
    output logic [PIX_W-1:0]   fb_rdata,
    input  logic               pal_we,
    input  logic [3:0]         pal_addr,
    input  logic [7:0]         pal_wdata,
    output logic [7:0]         pal_rdata,
    input  logic [IDX_W-1:0]   pix_ptr,
    output logic [COLOR_W-1:0] pix_color
);

    localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic [PIX_W-1:0] fb  [NUM_LEDS];
    logic [7:0]       pal [PAL_BYTES];
    logic [PIX_W-1:0] code;
    logic [3:0]       base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb  <= '{default: '0};
            pal <= '{default: '0};
        end else begin
            // IDX may be programmed beyond the buffer; such writes are dropped.
            if (fb_we && (32'(fb_waddr) < NUM_LEDS))
                fb[fb_waddr[AW-1:0]] <= fb_wdata;
            if (pal_we && (32'(pal_addr) < PAL_BYTES))
                pal[pal_addr] <= pal_wdata;
        end
    end

    always_comb begin
        fb_rdata  = '0;
        pal_rdata = '0;
        code      = '0;
        if (32'(fb_raddr) < NUM_LEDS)
            fb_rdata = fb[fb_raddr[AW-1:0]];
        if (32'(pal_addr) < PAL_BYTES)
            pal_rdata = pal[pal_addr];
        if (32'(pix_ptr) < NUM_LEDS)
            code = fb[pix_ptr[AW-1:0]];
        base      = pal_base(code);
        pix_color = {pal[base], pal[base + 4'd1], pal[base + 4'd2]};
    end

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Frame-level controller for the ws2812b serializer core.
// Streams LEN+1 palette-mapped pixels over valid/ready when START is written,
// flags the last pixel with px_latch, optionally repeats after GAP_CYCLES.
// Ports:
//  clk, rst_n  clock, async active-low reset
//  bus         TinyQV byte bus slave (register map: CTRL, LEN, IDX, PIX, palette)
//  px          pixel stream master towards the serializer core
module ws2812b_frame_sequencer
    import ws2812b_pkg::*;
#(
    parameter int NUM_LEDS   = 16,
    parameter int GAP_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    ws2812b_bus_if.slave  bus,
    ws2812b_px_if.master  px
);

    localparam logic [IDX_W-1:0] LAST     = IDX_W'(NUM_LEDS - 1);
    localparam int               GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP_CYCLES - 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   len;
    logic [IDX_W-1:0]   idx;
    logic               auto_en;
    logic               done;
    logic               busy;
    logic               abort_pend;
    logic [GW-1:0]      gap_cnt;

    logic               ctrl_wr;
    logic               len_wr;
    logic               idx_wr;
    logic               pix_wr;
    logic               pal_wr;
    logic [3:0]         pal_addr;
    logic [PIX_W-1:0]   fb_rdata;
    logic [7:0]         pal_rdata;
    logic [COLOR_W-1:0] pix_color;

    always_comb begin
        ctrl_wr  = bus.data_write && (bus.address == REG_CTRL);
        len_wr   = bus.data_write && (bus.address == REG_LEN);
        idx_wr   = bus.data_write && (bus.address == REG_IDX);
        pix_wr   = bus.data_write && (bus.address == REG_PIX);
        pal_wr   = bus.data_write && (bus.address >= REG_PAL0);
        pal_addr = bus.address - REG_PAL0;
    end

    ws2812b_frame_store #(
        .NUM_LEDS (NUM_LEDS)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .fb_we     (pix_wr),
        .fb_waddr  (idx),
        .fb_wdata  (bus.data_in[PIX_W-1:0]),
        .fb_raddr  (idx),
        .fb_rdata  (fb_rdata),
        .pal_we    (pal_wr),
        .pal_addr  (pal_addr),
        .pal_wdata (bus.data_in),
        .pal_rdata (pal_rdata),
        .pix_ptr   (ptr),
        .pix_color (pix_color)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            len         <= LAST;
            idx         <= '0;
            auto_en     <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            abort_pend  <= 1'b0;
            gap_cnt     <= '0;
            px.px_data  <= '0;
            px.px_valid <= 1'b0;
            px.px_latch <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                auto_en <= bus.data_in[CTRL_AUTO];
                if (busy && bus.data_in[CTRL_ABORT])
                    abort_pend <= 1'b1;
            end
            if (len_wr)
                len <= (bus.data_in > 8'(NUM_LEDS - 1)) ? LAST : bus.data_in[IDX_W-1:0];
            if (idx_wr)
                idx <= bus.data_in[IDX_W-1:0];
            else if (pix_wr)
                idx <= (idx >= LAST) ? '0 : idx + 1'b1;

            case (state)
                ST_IDLE: begin
                    abort_pend <= 1'b0;
                    if (ctrl_wr && bus.data_in[CTRL_START]) begin
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        ptr   <= '0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    px.px_data  <= pix_color;
                    // >= so that lowering LEN below ptr ends the frame on this pixel
                    px.px_latch <= (ptr >= len);
                    px.px_valid <= 1'b1;
                    state       <= ST_SEND;
                end
                ST_SEND: begin
                    if (!px.px_ready) begin
                        px.px_valid <= 1'b0;
                        state       <= ST_WAITRDY;
                    end
                end
                ST_WAITRDY: begin
                    if (px.px_ready) begin
                        if (abort_pend) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        // the latch flag of the pixel just sent marks frame end,
                        // immune to LEN writes after it was loaded
                        end else if (px.px_latch) begin
                            done <= 1'b1;
                            if (auto_en) begin
                                gap_cnt <= GAP_LOAD;
                                state   <= ST_GAP;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    if (abort_pend || !auto_en) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (gap_cnt == '0) begin
                        ptr   <= '0;
                        state <= ST_LOAD;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.data_out = '0;
        case (bus.address)
            REG_CTRL: bus.data_out = {5'b0, auto_en, done, busy};
            REG_LEN:  bus.data_out = {2'b0, len};
            REG_IDX:  bus.data_out = {2'b0, idx};
            REG_PIX:  bus.data_out = {6'b0, fb_rdata};
            default:  bus.data_out = pal_rdata;
        endcase
    end

endmodule
